// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_HOLD,
        PC_REDIRECT,
        PC_TRAP,
        PC_RET
    } pc_sel_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: push/pop take effect on the clock edge, top/empty are combinational.
// A push when full overwrites the oldest entry; push+pop replaces the top in place.
module ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic            do_pop;
    logic [PW-1:0]   wr_idx;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign top    = mem[ptr];
    // A simultaneous pop frees the top slot, so the push lands there instead of above it.
    assign wr_idx = do_pop ? ptr : ptr + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !do_pop) begin
            ptr <= ptr + PW'(1);
            if (count != CW'(RAS_DEPTH))
                count <= count + CW'(1);
        end else if (do_pop && !push) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && push)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with trap/redirect/stall/return-prediction/sequential select and a return-address stack.
// One-cycle latency from inputs to pc; stall holds pc and suppresses call/return side effects.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            call_valid,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            ras_empty
);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            misalign;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;

    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    always_comb begin
        sel       = PC_SEQ;
        misalign  = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        // The first edge after reset only validates the reset vector.
        if (!pc_valid) begin
            sel = PC_HOLD;
        end else if (trap_valid) begin
            sel       = PC_TRAP;
            ras_clear = 1'b1;
        end else if (redirect_valid) begin
            if (redirect_target[1:0] == 2'b00) begin
                sel = PC_REDIRECT;
            end else begin
                sel      = PC_HOLD;
                misalign = 1'b1;
            end
        end else if (stall) begin
            sel = PC_HOLD;
        end else begin
            ras_push = call_valid;
            ras_pop  = ret_valid && !ras_empty;
            sel      = ras_pop ? PC_RET : PC_SEQ;
        end
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            PC_SEQ:      pc_next = pc_plus4;
            PC_HOLD:     pc_next = pc;
            PC_REDIRECT: pc_next = redirect_target;
            PC_TRAP:     pc_next = trap_vector;
            PC_RET:      pc_next = ras_top;
            default:     pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            pc_valid     <= 1'b1;
            misalign_err <= misalign;
        end
    end

    ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule
